// File: rtl/serdes_link_seq.sv
// Power-up / recovery sequencer for an NL-lane SERDES PHY: PLL, TX reset, receiver detect, RX reset, CDR lock.
// Optional feature: define SERDES_RXDET_RETRY_EN to retry an empty receiver detect up to two times before FAULT.
module serdes_link_seq #(
  parameter int NL      = 1,
  parameter int PLL_TO  = 1023,
  parameter int RST_CYC = 16,
  parameter int DET_CYC = 64,
  parameter int CDR_TO  = 1023
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          pll_lock_i,
  input  logic [NL-1:0] rxpresent_i,
  input  logic [NL-1:0] cdr_lock_i,
  output logic          pll_pd_o,
  output logic          tx_rst_o,
  output logic [NL-1:0] rx_rst_o,
  output logic          rxdet_en_o,
  output logic [NL-1:0] lane_active_o,
  output logic          ready_o,
  output logic          fault_o,
  output logic [2:0]    state_o
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PLL_WAIT = 3'd1,
    ST_TX_RST   = 3'd2,
    ST_RX_DET   = 3'd3,
    ST_RX_RST   = 3'd4,
    ST_CDR_WAIT = 3'd5,
    ST_READY    = 3'd6,
    ST_FAULT    = 3'd7
  } state_e;

  localparam int MAX_A   = (PLL_TO > RST_CYC) ? PLL_TO : RST_CYC;
  localparam int MAX_B   = (DET_CYC > CDR_TO) ? DET_CYC : CDR_TO;
  localparam int MAX_ALL = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(MAX_ALL) + 1;

  localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};
  localparam logic [CW-1:0] PLL_LAST = CW'(PLL_TO - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] DET_LAST = CW'(DET_CYC - 1);
  localparam logic [CW-1:0] CDR_LAST = CW'(CDR_TO - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NL-1:0]   mask_q, mask_d;
  logic            pll_pd_d, tx_rst_d, rxdet_en_d, ready_d, fault_d;
  logic [NL-1:0]   rx_rst_d, lane_active_d;
`ifdef SERDES_RXDET_RETRY_EN
  logic [1:0]      retry_q, retry_d;
`endif

  // Next-state, detect-mask and retry logic; dropping start overrides everything.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
`ifdef SERDES_RXDET_RETRY_EN
    retry_d = retry_q;
`endif
    if (!start_i) begin
      state_d = ST_IDLE;
      mask_d  = {NL{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_PLL_WAIT;
`ifdef SERDES_RXDET_RETRY_EN
          retry_d = 2'd0;
`endif
        end
        ST_PLL_WAIT: begin
          if (pll_lock_i) begin
            state_d = ST_TX_RST;
          end else if (cnt_q == PLL_LAST) begin
            state_d = ST_FAULT;
          end else begin
            state_d = state_q;
          end
        end
        ST_TX_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_RX_DET;
          end else begin
            state_d = state_q;
          end
        end
        ST_RX_DET: begin
          if (cnt_q == DET_LAST) begin
            mask_d = rxpresent_i;
            if (rxpresent_i != {NL{1'b0}}) begin
              state_d = ST_RX_RST;
            end else begin
`ifdef SERDES_RXDET_RETRY_EN
              if (retry_q < 2'd2) begin
                state_d = ST_TX_RST;
                retry_d = retry_q + 2'd1;
              end else begin
                state_d = ST_FAULT;
              end
`else
              state_d = ST_FAULT;
`endif
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_RX_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_CDR_WAIT;
          end else begin
            state_d = state_q;
          end
        end
        ST_CDR_WAIT: begin
          if ((cdr_lock_i & mask_q) == mask_q) begin
            state_d = ST_READY;
          end else if (cnt_q == CDR_LAST) begin
            state_d = ST_FAULT;
          end else begin
            state_d = state_q;
          end
        end
        ST_READY: begin
          // PLL loss outranks a simultaneous CDR loss.
          if (!pll_lock_i) begin
            state_d = ST_PLL_WAIT;
            mask_d  = {NL{1'b0}};
          end else if ((cdr_lock_i & mask_q) != mask_q) begin
            state_d = ST_RX_RST;
          end else begin
            state_d = state_q;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default: begin
          state_d = ST_IDLE;
          mask_d  = {NL{1'b0}};
        end
      endcase
    end
  end

  // Saturating dwell counter, cleared on every state change.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output decode from the upcoming state so the registered outputs track state_q exactly.
  always_comb begin
    pll_pd_d      = 1'b1;
    tx_rst_d      = 1'b1;
    rx_rst_d      = {NL{1'b1}};
    rxdet_en_d    = 1'b0;
    lane_active_d = {NL{1'b0}};
    ready_d       = 1'b0;
    fault_d       = 1'b0;
    case (state_d)
      ST_IDLE:     pll_pd_d = 1'b1;
      ST_PLL_WAIT: pll_pd_d = 1'b0;
      ST_TX_RST:   pll_pd_d = 1'b0;
      ST_RX_DET: begin
        pll_pd_d   = 1'b0;
        tx_rst_d   = 1'b0;
        rxdet_en_d = 1'b1;
      end
      ST_RX_RST: begin
        pll_pd_d = 1'b0;
        tx_rst_d = 1'b0;
      end
      ST_CDR_WAIT: begin
        pll_pd_d = 1'b0;
        tx_rst_d = 1'b0;
        rx_rst_d = ~mask_d;
      end
      ST_READY: begin
        pll_pd_d      = 1'b0;
        tx_rst_d      = 1'b0;
        rx_rst_d      = ~mask_d;
        lane_active_d = mask_d;
        ready_d       = 1'b1;
      end
      ST_FAULT:    fault_d = 1'b1;
      default:     fault_d = 1'b0;
    endcase
  end

  // State, counter, mask and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= {CW{1'b0}};
      mask_q        <= {NL{1'b0}};
      pll_pd_o      <= 1'b1;
      tx_rst_o      <= 1'b1;
      rx_rst_o      <= {NL{1'b1}};
      rxdet_en_o    <= 1'b0;
      lane_active_o <= {NL{1'b0}};
      ready_o       <= 1'b0;
      fault_o       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mask_q        <= mask_d;
      pll_pd_o      <= pll_pd_d;
      tx_rst_o      <= tx_rst_d;
      rx_rst_o      <= rx_rst_d;
      rxdet_en_o    <= rxdet_en_d;
      lane_active_o <= lane_active_d;
      ready_o       <= ready_d;
      fault_o       <= fault_d;
    end
  end

`ifdef SERDES_RXDET_RETRY_EN
  // Empty-detect retry counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retry_q <= 2'd0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  assign state_o = state_q;

endmodule

// File: tb/tb_serdes_link_seq.sv
// Scoreboard bench for serdes_link_seq with NL=4: expected output vectors are queued per cycle and popped after each edge.
module tb_serdes_link_seq;

  localparam int NL      = 4;
  localparam int PLL_TO  = 1023;
  localparam int RST_CYC = 16;
  localparam int DET_CYC = 64;
  localparam int CDR_TO  = 1023;
`ifdef SERDES_RXDET_RETRY_EN
  localparam int WINDOWS = 3;
`else
  localparam int WINDOWS = 1;
`endif

  typedef struct packed {
    logic [2:0] st;
    logic       pll_pd;
    logic       tx_rst;
    logic [3:0] rx_rst;
    logic       rxdet_en;
    logic [3:0] lane;
    logic       ready;
    logic       fault;
  } outs_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          pll_lock_i = 1'b0;
  logic [NL-1:0] rxpresent_i = 4'h0;
  logic [NL-1:0] cdr_lock_i = 4'h0;
  logic          pll_pd_o, tx_rst_o, rxdet_en_o, ready_o, fault_o;
  logic [NL-1:0] rx_rst_o, lane_active_o;
  logic [2:0]    state_o;

  int    errors = 0;
  int    checks = 0;
  outs_t exp_q[$];
  outs_t exp_s;
  outs_t obs_s;

  serdes_link_seq #(.NL(NL), .PLL_TO(PLL_TO), .RST_CYC(RST_CYC), .DET_CYC(DET_CYC), .CDR_TO(CDR_TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pll_lock_i(pll_lock_i),
    .rxpresent_i(rxpresent_i), .cdr_lock_i(cdr_lock_i), .pll_pd_o(pll_pd_o),
    .tx_rst_o(tx_rst_o), .rx_rst_o(rx_rst_o), .rxdet_en_o(rxdet_en_o),
    .lane_active_o(lane_active_o), .ready_o(ready_o), .fault_o(fault_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  assign obs_s = {state_o, pll_pd_o, tx_rst_o, rx_rst_o, rxdet_en_o, lane_active_o, ready_o, fault_o};

  // Expected outputs for a given state and latched mask, straight from the state table.
  function automatic outs_t model(input logic [2:0] st, input logic [3:0] m);
    outs_t o;
    o.st       = st;
    o.pll_pd   = (st == 3'd0) || (st == 3'd7);
    o.tx_rst   = (st <= 3'd2) || (st == 3'd7);
    o.rx_rst   = ((st == 3'd5) || (st == 3'd6)) ? ~m : 4'hF;
    o.rxdet_en = (st == 3'd3);
    o.lane     = (st == 3'd6) ? m : 4'h0;
    o.ready    = (st == 3'd6);
    o.fault    = (st == 3'd7);
    return o;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b1;
    tick();
    exp_q.push_back(model(3'd0, 4'h0));
    tick();
    exp_s = exp_q.pop_front(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL reset_hold got=%h exp=%h", obs_s, exp_s); end
    rst_i = 1'b0; start_i = 1'b0;
    exp_q.push_back(model(3'd0, 4'h0));
    tick();
    exp_s = exp_q.pop_front(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL reset_idle got=%h exp=%h", obs_s, exp_s); end
  endtask

  task automatic test_happy_path();
    logic [2:0] st;
    pll_lock_i = 1'b1; rxpresent_i = 4'b1011; cdr_lock_i = 4'b1111; start_i = 1'b1;
    for (int c = 1; c <= 99; c++) begin
      if (c == 1) st = 3'd1;
      else if (c <= 17) st = 3'd2;
      else if (c <= 81) st = 3'd3;
      else if (c <= 97) st = 3'd4;
      else if (c == 98) st = 3'd5;
      else st = 3'd6;
      exp_q.push_back(model(st, 4'b1011));
      tick();
      exp_s = exp_q.pop_front(); checks++;
      if (obs_s !== exp_s) begin errors++; $display("FAIL happy c=%0d got=%h exp=%h", c, obs_s, exp_s); end
    end
  endtask

  task automatic test_cdr_drop();
    logic [2:0] st;
    cdr_lock_i = 4'b1011;
    exp_q.push_back(model(3'd6, 4'b1011));
    tick();
    exp_s = exp_q.pop_front(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL unmasked_drop got=%h exp=%h", obs_s, exp_s); end
    cdr_lock_i = 4'b1101;
    exp_q.push_back(model(3'd4, 4'b1011));
    tick();
    exp_s = exp_q.pop_front(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL cdr_drop got=%h exp=%h", obs_s, exp_s); end
    cdr_lock_i = 4'b1111;
    for (int c = 1; c <= RST_CYC + 1; c++) begin
      if (c < RST_CYC) st = 3'd4;
      else if (c == RST_CYC) st = 3'd5;
      else st = 3'd6;
      exp_q.push_back(model(st, 4'b1011));
      tick();
      exp_s = exp_q.pop_front(); checks++;
      if (obs_s !== exp_s) begin errors++; $display("FAIL cdr_recover c=%0d got=%h exp=%h", c, obs_s, exp_s); end
    end
  endtask

  task automatic test_pll_loss_timeout();
    pll_lock_i = 1'b0; cdr_lock_i = 4'b1110;
    exp_q.push_back(model(3'd1, 4'h0));
    tick();
    exp_s = exp_q.pop_front(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL pll_loss got=%h exp=%h", obs_s, exp_s); end
    for (int c = 1; c <= PLL_TO + 2; c++) begin
      exp_q.push_back(model((c < PLL_TO) ? 3'd1 : 3'd7, 4'h0));
      tick();
      exp_s = exp_q.pop_front();
      if (c >= PLL_TO - 2) begin
        checks++;
        if (obs_s !== exp_s) begin errors++; $display("FAIL pll_timeout c=%0d got=%h exp=%h", c, obs_s, exp_s); end
      end
    end
    start_i = 1'b0;
    exp_q.push_back(model(3'd0, 4'h0));
    tick();
    exp_s = exp_q.pop_front(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL fault_exit got=%h exp=%h", obs_s, exp_s); end
  endtask

  task automatic test_empty_detect();
    logic [2:0] st;
    int k;
    pll_lock_i = 1'b1; rxpresent_i = 4'h0; cdr_lock_i = 4'hF; start_i = 1'b1;
    for (int c = 1; c <= 2 + (RST_CYC + DET_CYC) * WINDOWS + 2; c++) begin
      k = c - 2;
      if (c == 1) st = 3'd1;
      else if (k >= (RST_CYC + DET_CYC) * WINDOWS) st = 3'd7;
      else if ((k % (RST_CYC + DET_CYC)) < RST_CYC) st = 3'd2;
      else st = 3'd3;
      exp_q.push_back(model(st, 4'h0));
      tick();
      exp_s = exp_q.pop_front(); checks++;
      if (obs_s !== exp_s) begin errors++; $display("FAIL empty_det c=%0d got=%h exp=%h", c, obs_s, exp_s); end
    end
    start_i = 1'b0;
    tick();
  endtask

  task automatic test_rst_in_cdr_wait();
    pll_lock_i = 1'b1; rxpresent_i = 4'b0110; cdr_lock_i = 4'b0000; start_i = 1'b1;
    repeat (99) tick();
    exp_q.push_back(model(3'd5, 4'b0110));
    tick();
    exp_s = exp_q.pop_front(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL cdr_wait got=%h exp=%h", obs_s, exp_s); end
    rst_i = 1'b1;
    exp_q.push_back(model(3'd0, 4'h0));
    tick();
    exp_s = exp_q.pop_front(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL rst_mid got=%h exp=%h", obs_s, exp_s); end
    rst_i = 1'b0;
    exp_q.push_back(model(3'd1, 4'h0));
    tick();
    exp_s = exp_q.pop_front(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL rst_release got=%h exp=%h", obs_s, exp_s); end
    start_i = 1'b0;
    tick();
  endtask

  task automatic test_start_drop_rxdet();
    pll_lock_i = 1'b1; rxpresent_i = 4'b1111; start_i = 1'b1;
    repeat (29) tick();
    exp_q.push_back(model(3'd3, 4'h0));
    tick();
    exp_s = exp_q.pop_front(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL in_rxdet got=%h exp=%h", obs_s, exp_s); end
    start_i = 1'b0;
    exp_q.push_back(model(3'd0, 4'h0));
    tick();
    exp_s = exp_q.pop_front(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL start_drop got=%h exp=%h", obs_s, exp_s); end
  endtask

  initial begin
    test_reset();
    test_happy_path();
    test_cdr_drop();
    test_pll_loss_timeout();
    test_empty_detect();
    test_rst_in_cdr_wait();
    test_start_drop_rxdet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
